// File: rtl/mux_pkg.sv
// Shared constants for the mux_arb channel arbiter: selection modes and default geometry.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  localparam int N_CH_DEF = 8;
  localparam int W_DEF    = 8;

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Rotating-priority finder: first set request after ptr, wrapping, ending at ptr itself.
module rr_pick #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    // offsets 1..N put ptr itself last in the search order
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = SW'(j);
      end
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N-channel valid/ready mux with external-select or round-robin arbitration and a registered output.
// Optional MUX_ARB_COUNT_EN adds a 16-bit wrapping output-beat counter port (beat_cnt).
module mux_arb
  import mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF,
  parameter int MODE = MODE_RR
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(N_CH)-1:0]   s,
  input  logic [N_CH*W-1:0]         d,
  input  logic [N_CH-1:0]           d_valid,
  output logic [N_CH-1:0]           d_ready,
  output logic [W-1:0]              y,
  output logic [$clog2(N_CH)-1:0]   y_ch,
  output logic                      y_valid,
  input  logic                      y_ready
`ifdef MUX_ARB_COUNT_EN
  ,
  output logic [15:0]               beat_cnt
`endif
);

  localparam int SW = $clog2(N_CH);

  logic            ld;
  logic            xfer;
  logic [N_CH-1:0] gnt_oh;
  logic [SW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [W-1:0]    sel_data;

  assign ld = !y_valid || y_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] ptr;
      logic          unused_s;

      assign unused_s = ^s;

      rr_pick #(.N(N_CH), .SW(SW)) u_pick (
        .req   (d_valid),
        .ptr   (ptr),
        .grant (gnt_oh),
        .idx   (gnt_idx),
        .any   (gnt_any)
      );

      // reset to the last channel so the first search begins at channel 0
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          ptr <= SW'(N_CH - 1);
        else if (xfer)
          ptr <= gnt_idx;
      end
    end else begin : g_sel
      always_comb begin
        gnt_oh  = '0;
        gnt_idx = s;
        gnt_any = 1'b0;
        if ((int'(s) < N_CH) && d_valid[s]) begin
          gnt_any    = 1'b1;
          gnt_oh[s]  = 1'b1;
        end
      end
    end
  endgenerate

  assign d_ready = (ld && gnt_any && !reset) ? gnt_oh : '0;
  assign xfer    = |(d_ready & d_valid);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == SW'(i))
        sel_data = d[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else if (xfer) begin
      y       <= sel_data;
      y_ch    <= gnt_idx;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      beat_cnt <= '0;
    else if (y_valid && y_ready)
      beat_cnt <= beat_cnt + 16'd1;
  end
`endif

endmodule
